seg_scan_ctrl: RTL and testbench

//  Time-multiplexed scan controller for a multi-digit common-anode 7-segment display.

---
 rtl/seg_scan_ctrl_pkg.sv | 22 ++
 rtl/seg_scan_prescaler.sv | 50 +++++
 rtl/seg_scan_ctrl.sv | 144 ++++++++++++++
 tb/tb_seg_scan_ctrl.sv | 268 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/seg_scan_ctrl_pkg.sv
// Shared definitions for the 7-segment scan controller and its decoder partner.
package seg_scan_ctrl_pkg;

    // Width of the BCD/hex code handed to the seg_display decoder (A..D).
    localparam int CODE_W = 4;

    // Per-slot phase: dark guard interval, then the digit is lit.
    typedef enum logic {
        ST_BLANK = 1'b0,
        ST_SHOW  = 1'b1
    } scanState_t;

    // Ceiling log2, never below 1 so a single-digit or tiny divider still
    // gets a legal one-bit counter.
    function automatic int CLOG2(input int value);
        int w;
        w = 1;
        while ((1 << w) < value) w++;
        return w;
    endfunction

endpackage

// File: rtl/seg_scan_prescaler.sv
// Slot prescaler and digit index for the scan controller, plus the frame pulse.
module seg_scan_prescaler
    import seg_scan_ctrl_pkg::*;
#(
    parameter int NUM_DIGITS = 4,
    parameter int SCAN_DIV   = 1000
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic                          en,
    output logic [CLOG2(SCAN_DIV)-1:0]    cnt,
    output logic [CLOG2(NUM_DIGITS)-1:0]  idx,
    output logic                          slotEnd,
    output logic                          wrap,
    output logic                          frameTick
);

    localparam int CNT_W = CLOG2(SCAN_DIV);
    localparam int IDX_W = CLOG2(NUM_DIGITS);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(SCAN_DIV - 1);
    localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(NUM_DIGITS - 1);

    // Slot end and frame wrap only exist while scanning.
    assign slotEnd = en && (cnt == CNT_LAST);
    assign wrap    = slotEnd && (idx == IDX_LAST);

    // Cycle-in-slot counter and digit index; en=0 parks both at zero.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt <= '0;
            idx <= '0;
        end else if (!en) begin
            cnt <= '0;
            idx <= '0;
        end else if (slotEnd) begin
            cnt <= '0;
            idx <= wrap ? '0 : idx + 1'b1;
        end else begin
            cnt <= cnt + 1'b1;
        end
    end

    // Frame pulse is registered alongside the digit outputs so it lands in
    // the first cycle of the new frame.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) frameTick <= 1'b0;
        else        frameTick <= wrap;
    end

endmodule

// File: rtl/seg_scan_ctrl.sv
// Multiplexed common-anode 7-segment scan controller: double-buffered display
// data, blanking gap at the start of each digit slot, leading-zero blanking.
module seg_scan_ctrl
    import seg_scan_ctrl_pkg::*;
#(
    parameter int NUM_DIGITS = 4,
    parameter int SCAN_DIV   = 1000,
    parameter int BLANK_CYC  = 8,
    parameter int LZB        = 1
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic                         en,
    input  logic                         load,
    input  logic [CODE_W*NUM_DIGITS-1:0] load_val,
    input  logic [NUM_DIGITS-1:0]        load_dp,
    output logic                         load_ready,
    output logic [CODE_W-1:0]            dig_code,
    output logic                         dig_dp,
    output logic                         dig_blank,
    output logic [NUM_DIGITS-1:0]        dig_en_n,
    output logic                         frame_tick
);

    localparam int CNT_W = CLOG2(SCAN_DIV);
    localparam int IDX_W = CLOG2(NUM_DIGITS);
    // Last dark cycle of a slot; BLANK_CYC is assumed to be at least 1.
    localparam logic [CNT_W-1:0] SHOW_START = CNT_W'(BLANK_CYC - 1);

    logic [CNT_W-1:0] cnt;
    logic [IDX_W-1:0] idx;
    logic             slotEnd;
    logic             wrap;

    scanState_t state, stateNext;

    logic [NUM_DIGITS-1:0][CODE_W-1:0] disp, shadow;
    logic [NUM_DIGITS-1:0]             dispDp, shadowDp;
    logic                              pending;
    logic                              commit, capture;
    logic [NUM_DIGITS-1:0]             lzBlank;

    logic [NUM_DIGITS-1:0] enNext;
    logic [CODE_W-1:0]     codeNext;
    logic                  dpNext, blankNext;

    seg_scan_prescaler #(
        .NUM_DIGITS (NUM_DIGITS),
        .SCAN_DIV   (SCAN_DIV)
    ) uPrescaler (
        .clk       (clk),
        .rst_n     (rst_n),
        .en        (en),
        .cnt       (cnt),
        .idx       (idx),
        .slotEnd   (slotEnd),
        .wrap      (wrap),
        .frameTick (frame_tick)
    );

    // A staged value moves to the display at a frame boundary, or straight
    // away once scanning stops, so nothing is ever torn mid-frame.
    assign capture    = load && !pending;
    assign commit     = pending && (wrap || !en);
    assign load_ready = !pending;

    // Shadow/display double buffer and its occupancy flag.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            shadow   <= '0;
            shadowDp <= '0;
            disp     <= '0;
            dispDp   <= '0;
            pending  <= 1'b0;
        end else begin
            if (capture) begin
                shadow   <= load_val;
                shadowDp <= load_dp;
                pending  <= 1'b1;
            end
            if (commit) begin
                disp    <= shadow;
                dispDp  <= shadowDp;
                pending <= 1'b0;
            end
        end
    end

    // Leading-zero mask: digit k>0 goes dark when it and every more
    // significant digit are zero and it carries no decimal point.
    always_comb begin
        logic allZero;
        allZero = 1'b1;
        lzBlank = '0;
        for (int k = NUM_DIGITS - 1; k > 0; k--) begin
            allZero    = allZero && (disp[k] == '0);
            lzBlank[k] = (LZB != 0) && allZero && !dispDp[k];
        end
    end

    // Slot phase register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= ST_BLANK;
        else        state <= stateNext;
    end

    // Next phase and next output values; dark unless scanning in SHOW.
    always_comb begin
        stateNext = state;
        enNext    = '1;
        codeNext  = '0;
        dpNext    = 1'b0;
        blankNext = 1'b1;

        if (!en || slotEnd) begin
            stateNext = ST_BLANK;
        end else if (state == ST_BLANK && cnt == SHOW_START) begin
            stateNext = ST_SHOW;
        end

        if (en && state == ST_SHOW) begin
            enNext[idx] = 1'b0;
            codeNext    = disp[idx];
            dpNext      = dispDp[idx];
            blankNext   = lzBlank[idx];
        end
    end

    // Output registers; reset darkens the display without waiting for a clock.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            dig_en_n  <= '1;
            dig_blank <= 1'b1;
            dig_code  <= '0;
            dig_dp    <= 1'b0;
        end else begin
            dig_en_n  <= enNext;
            dig_blank <= blankNext;
            dig_code  <= codeNext;
            dig_dp    <= dpNext;
        end
    end

endmodule

// File: tb/tb_seg_scan_ctrl.sv
// Directed bench for seg_scan_ctrl with a frame-level reference model.
module tb_seg_scan_ctrl;

    localparam int ND = 4;
    localparam int SD = 10;
    localparam int BC = 2;

    logic        clk = 1'b0;
    logic        rst_n = 1'b1;
    logic        en = 1'b0;
    logic        load = 1'b0;
    logic [15:0] load_val = '0;
    logic [3:0]  load_dp = '0;
    logic        load_ready;
    logic [3:0]  dig_code;
    logic        dig_dp;
    logic        dig_blank;
    logic [3:0]  dig_en_n;
    logic        frame_tick;

    int total = 0;
    int bad = 0;
    bit chkOn = 0;

    seg_scan_ctrl #(.NUM_DIGITS(ND), .SCAN_DIV(SD), .BLANK_CYC(BC), .LZB(1)) dut (
        .clk(clk), .rst_n(rst_n), .en(en), .load(load), .load_val(load_val),
        .load_dp(load_dp), .load_ready(load_ready), .dig_code(dig_code),
        .dig_dp(dig_dp), .dig_blank(dig_blank), .dig_en_n(dig_en_n),
        .frame_tick(frame_tick)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s actual=%h expected=%h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: time since scanning started gives slot/digit directly.
    int          p = 0;
    logic [15:0] mDisp = '0, mShadow = '0;
    logic [3:0]  mDp = '0, mShDp = '0;
    bit          mPend = 0;
    logic [3:0]  expEnN = 4'hF;
    logic [3:0]  expCode = '0;
    bit          expBlank = 1, expDp = 0, expTick = 0;

    function automatic bit lzOff(input logic [15:0] v, input logic [3:0] dp, input int k);
        if (k == 0) return 0;
        for (int j = ND - 1; j >= k; j--)
            if (v[j*4 +: 4] != 4'h0) return 0;
        return !dp[k];
    endfunction

    initial begin
        int c, d;
        bit w;
        forever begin
            @(posedge clk or negedge rst_n);
            if (!rst_n) begin
                p = 0; mDisp = '0; mShadow = '0; mDp = '0; mShDp = '0; mPend = 0;
                expEnN = 4'hF; expBlank = 1; expCode = '0; expDp = 0; expTick = 0;
            end else begin
                c = p % SD;
                d = (p / SD) % ND;
                if (en && c >= BC) begin
                    expEnN = 4'hF;
                    expEnN[d] = 1'b0;
                    expCode = mDisp[d*4 +: 4];
                    expDp = mDp[d];
                    expBlank = lzOff(mDisp, mDp, d);
                end else begin
                    expEnN = 4'hF; expBlank = 1; expCode = '0; expDp = 0;
                end
                w = en && (c == SD - 1) && (d == ND - 1);
                expTick = w;
                if (mPend && (w || !en)) begin
                    mDisp = mShadow; mDp = mShDp; mPend = 0;
                end else if (load && !mPend) begin
                    mShadow = load_val; mShDp = load_dp; mPend = 1;
                end
                p = en ? p + 1 : 0;
            end
        end
    end

    // Every-cycle comparison against the model.
    always @(negedge clk) begin
        if (chkOn) begin
            check("en_n", {12'h0, dig_en_n}, {12'h0, expEnN});
            check("blank", {15'h0, dig_blank}, {15'h0, expBlank});
            check("tick", {15'h0, frame_tick}, {15'h0, expTick});
            check("ready", {15'h0, load_ready}, {15'h0, !mPend});
            if (expEnN != 4'hF) begin
                check("code", {12'h0, dig_code}, {12'h0, expCode});
                check("dp", {15'h0, dig_dp}, {15'h0, expDp});
            end
        end
    end

    logic [3:0] sEn [0:40];
    logic [3:0] sCode [0:40];
    bit         sBlank [0:40];
    bit         sDp [0:40];
    bit         sTick [0:40];

    task automatic pulseLoad(input logic [15:0] v, input logic [3:0] dp);
        @(posedge clk); #1;
        load = 1'b1; load_val = v; load_dp = dp;
        @(posedge clk); #1;
        load = 1'b0;
    endtask

    task automatic waitTick(input string tag);
        int n;
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!frame_tick && n < 200);
        check(tag, {15'h0, frame_tick}, 16'h1);
    endtask

    // Capture one full frame following a frame_tick cycle.
    task automatic sampleWindow();
        for (int i = 1; i <= 40; i++) begin
            @(negedge clk);
            sEn[i] = dig_en_n; sCode[i] = dig_code; sBlank[i] = dig_blank;
            sDp[i] = dig_dp; sTick[i] = frame_tick;
        end
    endtask

    initial begin
        int n, dark, ticks, fives;

        // Reset state.
        en = 1'b1;
        #2 rst_n = 1'b0; chkOn = 1;
        #1;
        check("rst_en_n", {12'h0, dig_en_n}, 16'h000F);
        check("rst_blank", {15'h0, dig_blank}, 16'h1);
        check("rst_code", {12'h0, dig_code}, 16'h0);
        check("rst_ready", {15'h0, load_ready}, 16'h1);
        check("rst_tick", {15'h0, frame_tick}, 16'h0);
        repeat (3) @(negedge clk);
        rst_n = 1'b1;

        // 1: async reset while a digit is lit, with a load pending.
        pulseLoad(16'h4321, 4'h0);
        n = 0;
        do begin @(negedge clk); n++; end while (dig_en_n == 4'hF && n < 100);
        check("t1_lit", {12'h0, dig_en_n}, 16'h000E);
        #2 rst_n = 1'b0;
        #1;
        check("t1_async_en_n", {12'h0, dig_en_n}, 16'h000F);
        check("t1_async_blank", {15'h0, dig_blank}, 16'h1);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        check("t1_ready", {15'h0, load_ready}, 16'h1);

        // 2: 1234 scanned digit by digit.
        pulseLoad(16'h1234, 4'h0);
        waitTick("t2_tick_wait");
        sampleWindow();
        dark = 0; ticks = 0;
        for (int i = 1; i <= 40; i++) begin
            if (sEn[i] == 4'hF) dark++;
            if (i < 40 && sTick[i]) ticks++;
        end
        check("t2_dark_count", 16'(dark), 16'd8);
        check("t2_no_early_tick", 16'(ticks), 16'd0);
        check("t2_tick40", {15'h0, sTick[40]}, 16'h1);
        check("t2_dark1", {12'h0, sEn[2]}, 16'h000F);
        check("t2_en_d0", {12'h0, sEn[3]}, 16'h000E);
        check("t2_code_d0", {12'h0, sCode[3]}, 16'h4);
        check("t2_last_d0", {12'h0, sEn[10]}, 16'h000E);
        check("t2_gap", {12'h0, sEn[11]}, 16'h000F);
        check("t2_en_d1", {12'h0, sEn[13]}, 16'h000D);
        check("t2_code_d1", {12'h0, sCode[13]}, 16'h3);
        check("t2_en_d2", {12'h0, sEn[23]}, 16'h000B);
        check("t2_code_d2", {12'h0, sCode[23]}, 16'h2);
        check("t2_en_d3", {12'h0, sEn[33]}, 16'h0007);
        check("t2_code_d3", {12'h0, sCode[33]}, 16'h1);

        // 3: ABCD mid-frame, 5555 while busy is dropped.
        repeat (15) @(negedge clk);
        pulseLoad(16'hABCD, 4'h0);
        @(negedge clk);
        check("t3_ready_low", {15'h0, load_ready}, 16'h0);
        pulseLoad(16'h5555, 4'h0);
        waitTick("t3_tick_wait");
        sampleWindow();
        fives = 0;
        for (int i = 1; i <= 40; i++)
            if (sEn[i] != 4'hF && sCode[i] == 4'h5) fives++;
        check("t3_no_5555", 16'(fives), 16'd0);
        check("t3_code_d0", {12'h0, sCode[3]}, 16'hD);
        check("t3_code_d1", {12'h0, sCode[13]}, 16'hC);
        check("t3_code_d3", {12'h0, sCode[33]}, 16'hA);
        check("t3_ready_back", {15'h0, load_ready}, 16'h1);

        // 4: leading zeros of 0050.
        pulseLoad(16'h0050, 4'h0);
        waitTick("t4_tick_wait");
        sampleWindow();
        check("t4_d0_blank", {15'h0, sBlank[3]}, 16'h0);
        check("t4_d0_code", {12'h0, sCode[3]}, 16'h0);
        check("t4_d1_code", {12'h0, sCode[13]}, 16'h5);
        check("t4_d1_blank", {15'h0, sBlank[13]}, 16'h0);
        check("t4_d2_blank", {15'h0, sBlank[23]}, 16'h1);
        check("t4_d2_en", {12'h0, sEn[23]}, 16'h000B);
        check("t4_d3_blank", {15'h0, sBlank[33]}, 16'h1);

        // 5: all zero, then a decimal point stops the blanking.
        pulseLoad(16'h0000, 4'h0);
        waitTick("t5a_tick_wait");
        sampleWindow();
        check("t5a_d0_blank", {15'h0, sBlank[3]}, 16'h0);
        check("t5a_d1_blank", {15'h0, sBlank[13]}, 16'h1);
        check("t5a_d3_blank", {15'h0, sBlank[33]}, 16'h1);
        pulseLoad(16'h0012, 4'b0100);
        waitTick("t5b_tick_wait");
        sampleWindow();
        check("t5b_d0_code", {12'h0, sCode[3]}, 16'h2);
        check("t5b_d1_code", {12'h0, sCode[13]}, 16'h1);
        check("t5b_d2_blank", {15'h0, sBlank[23]}, 16'h0);
        check("t5b_d2_code", {12'h0, sCode[23]}, 16'h0);
        check("t5b_d2_dp", {15'h0, sDp[23]}, 16'h1);
        check("t5b_d3_blank", {15'h0, sBlank[33]}, 16'h1);

        // 6: en dropped mid-slot for 5 cycles with a load pending.
        pulseLoad(16'h0789, 4'h0);
        repeat (2) @(negedge clk);
        check("t6_lit_before", {12'h0, dig_en_n}, 16'h000E);
        @(posedge clk); #1 en = 1'b0;
        @(negedge clk);
        check("t6_still_lit", {12'h0, dig_en_n}, 16'h000E);
        check("t6_pending", {15'h0, load_ready}, 16'h0);
        @(negedge clk);
        check("t6_dark", {12'h0, dig_en_n}, 16'h000F);
        check("t6_commit", {15'h0, load_ready}, 16'h1);
        repeat (4) @(posedge clk);
        #1 en = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check("t6_restart_dark", {12'h0, dig_en_n}, 16'h000F);
        end
        @(negedge clk);
        check("t6_restart_en", {12'h0, dig_en_n}, 16'h000E);
        check("t6_restart_code", {12'h0, dig_code}, 16'h9);

        repeat (50) @(negedge clk);
        chkOn = 0;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog expired at %0t", $time);
        $fatal(1, "timeout");
    end

endmodule
